// File: rtl/alu_pkg.sv
// Shared ALU definitions: default widths, op codes and the buffered result entry layout.
package alu_pkg;

   localparam int unsigned N_DEFAULT    = 32;
   localparam int unsigned RA_W_DEFAULT = 5;

   typedef enum logic [3:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluXor,
      AluSll,
      AluSrl,
      AluSra,
      AluSlt,
      AluSltu,
      AluLui
   } alu_op_e;

   // Entry layout at default widths; the parameterised RTL carries the same fields flat.
   typedef struct packed {
      logic [N_DEFAULT-1:0]    res;
      logic [RA_W_DEFAULT-1:0] rd;
      logic                    wen;
      logic                    zero;
      logic                    neg;
   } alu_entry_t;

   // Occupancy of the skid buffer, derived from the {main, skid} valid bits.
   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StFull,
      StBad
   } skid_state_e;

endpackage

// File: rtl/result_slot.sv
// One load-enabled result entry: valid bit, payload, and zero/negative flags computed on load.
module result_slot
   import alu_pkg::*;
#(
   parameter int unsigned N    = N_DEFAULT,
   parameter int unsigned RA_W = RA_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_clr,
   input  logic [N-1:0]    i_res,
   input  logic [RA_W-1:0] i_rd,
   input  logic            i_wen,
   output logic            o_valid,
   output logic [N-1:0]    o_res,
   output logic [RA_W-1:0] o_rd,
   output logic            o_wen,
   output logic            o_zero,
   output logic            o_neg
);

   logic            r_valid;
   logic [N-1:0]    r_res;
   logic [RA_W-1:0] r_rd;
   logic            r_wen;
   logic            r_zero;
   logic            r_neg;

   // Load wins over clear; the controller never asserts both.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_res   <= '0;
         r_rd    <= '0;
         r_wen   <= 1'b0;
         r_zero  <= 1'b0;
         r_neg   <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_res   <= i_res;
         r_rd    <= i_rd;
         r_wen   <= i_wen;
         r_zero  <= (i_res == '0);
         r_neg   <= i_res[N-1];
      end else if (i_clr) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_res   = r_res;
   assign o_rd    = r_rd;
   assign o_wen   = r_wen;
   assign o_zero  = r_zero;
   assign o_neg   = r_neg;

endmodule

// File: rtl/alu_result_skid.sv
// Two-entry registered skid buffer between the ALU result mux and register-file writeback.
module alu_result_skid
   import alu_pkg::*;
#(
   parameter int unsigned N    = N_DEFAULT,
   parameter int unsigned RA_W = RA_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_res,
   input  logic [RA_W-1:0] in_rd,
   input  logic            in_wen,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_res,
   output logic [RA_W-1:0] out_rd,
   output logic            out_wen,
   output logic            out_zero,
   output logic            out_neg
);

   logic            r_in_ready;
   logic            w_in_ready_d;
   skid_state_e     w_state;
   logic            w_accept;
   logic            w_drain;
   logic            w_m_load;
   logic            w_m_clr;
   logic            w_m_from_s;
   logic            w_s_load;
   logic            w_s_clr;

   logic            w_m_valid;
   logic [N-1:0]    w_m_res;
   logic [RA_W-1:0] w_m_rd;
   logic            w_m_wen;
   logic            w_m_zero;
   logic            w_m_neg;

   logic            w_s_valid;
   logic [N-1:0]    w_s_res;
   logic [RA_W-1:0] w_s_rd;
   logic            w_s_wen;
   logic            w_s_zero;
   logic            w_s_neg;

   logic [N-1:0]    w_m_res_in;
   logic [RA_W-1:0] w_m_rd_in;
   logic            w_m_wen_in;

   assign w_accept = in_valid & r_in_ready;
   assign w_drain  = w_m_valid & out_ready;

   always_comb begin
      w_state = StBad;
      if (w_m_valid && w_s_valid) begin
         w_state = StFull;
      end else if (w_m_valid) begin
         w_state = StOne;
      end else if (!w_s_valid) begin
         w_state = StEmpty;
      end
   end

   always_comb begin
      w_m_load     = 1'b0;
      w_m_clr      = 1'b0;
      w_m_from_s   = 1'b0;
      w_s_load     = 1'b0;
      w_s_clr      = 1'b0;
      w_in_ready_d = r_in_ready;
      if (flush) begin
         // Any same-cycle accept is dropped; a same-cycle drain has already been sampled.
         w_m_clr      = 1'b1;
         w_s_clr      = 1'b1;
         w_in_ready_d = 1'b1;
      end else begin
         unique case (w_state)
            StEmpty: begin
               w_m_load     = w_accept;
               w_in_ready_d = 1'b1;
            end
            StOne: begin
               if (w_accept && w_drain) begin
                  w_m_load = 1'b1;
               end else if (w_accept) begin
                  w_s_load     = 1'b1;
                  w_in_ready_d = 1'b0;
               end else if (w_drain) begin
                  w_m_clr = 1'b1;
               end
            end
            StFull: begin
               if (w_drain) begin
                  w_m_load     = 1'b1;
                  w_m_from_s   = 1'b1;
                  w_s_clr      = 1'b1;
                  w_in_ready_d = 1'b1;
               end
            end
            default: begin
               w_m_clr      = 1'b1;
               w_s_clr      = 1'b1;
               w_in_ready_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_in_ready <= 1'b1;
      end else begin
         r_in_ready <= w_in_ready_d;
      end
   end

   assign w_m_res_in = w_m_from_s ? w_s_res : in_res;
   assign w_m_rd_in  = w_m_from_s ? w_s_rd  : in_rd;
   assign w_m_wen_in = w_m_from_s ? w_s_wen : in_wen;

   result_slot #(
      .N    (N),
      .RA_W (RA_W)
   ) u_main (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_m_load),
      .i_clr   (w_m_clr),
      .i_res   (w_m_res_in),
      .i_rd    (w_m_rd_in),
      .i_wen   (w_m_wen_in),
      .o_valid (w_m_valid),
      .o_res   (w_m_res),
      .o_rd    (w_m_rd),
      .o_wen   (w_m_wen),
      .o_zero  (w_m_zero),
      .o_neg   (w_m_neg)
   );

   result_slot #(
      .N    (N),
      .RA_W (RA_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_s_load),
      .i_clr   (w_s_clr),
      .i_res   (in_res),
      .i_rd    (in_rd),
      .i_wen   (in_wen),
      .o_valid (w_s_valid),
      .o_res   (w_s_res),
      .o_rd    (w_s_rd),
      .o_wen   (w_s_wen),
      .o_zero  (w_s_zero),
      .o_neg   (w_s_neg)
   );

   assign in_ready  = r_in_ready;
   assign out_valid = w_m_valid;
   assign out_res   = w_m_res;
   assign out_rd    = w_m_rd;
   assign out_wen   = w_m_valid & w_m_wen;
   assign out_zero  = w_m_zero;
   assign out_neg   = w_m_neg;

   a_no_orphan_skid : assert property (@(posedge clk) disable iff (rst)
      !(w_s_valid && !w_m_valid));

   a_skid_flags : assert property (@(posedge clk) disable iff (rst)
      !w_s_valid || ((w_s_zero == (w_s_res == '0)) && (w_s_neg == w_s_res[N-1])));

endmodule

// File: tb/tb_alu_result_skid.sv
// Directed and scoreboard-checked bench for the ALU result skid buffer.
module tb_alu_result_skid;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_res;
   logic [4:0]  in_rd;
   logic        in_wen;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_res;
   logic [4:0]  out_rd;
   logic        out_wen;
   logic        out_zero;
   logic        out_neg;

   int checks;
   int failures;

   alu_result_skid #(
      .N    (32),
      .RA_W (5)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_res    (in_res),
      .in_rd     (in_rd),
      .in_wen    (in_wen),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_rd    (out_rd),
      .out_wen   (out_wen),
      .out_zero  (out_zero),
      .out_neg   (out_neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] r, input logic [4:0] d,
                        input logic w);
      in_valid = v;
      in_res   = r;
      in_rd    = d;
      in_wen   = w;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checks++;
      if ({out_valid, out_wen, out_zero, out_neg, in_ready} !== 5'b00001) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=00001",
                  {out_valid, out_wen, out_zero, out_neg, in_ready});
      end
      checks++;
      if (out_res !== 32'h0) begin
         failures++;
         $display("FAIL reset_res got=%h exp=00000000", out_res);
      end
      checks++;
      if (out_rd !== 5'd0) begin
         failures++;
         $display("FAIL reset_rd got=%0d exp=0", out_rd);
      end
   endtask

   task automatic test_lui();
      logic [31:0] a;
      logic [31:0] lui;
      a   = 32'h0000ABCD;
      lui = {a[15:0], 16'h0000};
      out_ready = 1'b1;
      drive(1'b1, lui, 5'd3, 1'b1);
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      checks++;
      if ({out_valid, out_wen, out_zero, out_neg} !== 4'b1101) begin
         failures++;
         $display("FAIL lui_flags got=%b exp=1101", {out_valid, out_wen, out_zero, out_neg});
      end
      checks++;
      if (out_res !== 32'hABCD0000 || out_rd !== 5'd3) begin
         failures++;
         $display("FAIL lui_data got=%h/%0d exp=abcd0000/3", out_res, out_rd);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_wen !== 1'b0) begin
         failures++;
         $display("FAIL lui_drained got=%b%b exp=00", out_valid, out_wen);
      end
   endtask

   task automatic test_zero();
      out_ready = 1'b1;
      drive(1'b1, 32'h0, 5'd7, 1'b0);
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      checks++;
      if ({out_valid, out_zero, out_neg, out_wen} !== 4'b1100) begin
         failures++;
         $display("FAIL zero_flags got=%b exp=1100", {out_valid, out_zero, out_neg, out_wen});
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL zero_drained got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      drive(1'b1, 32'h11, 5'd1, 1'b1);
      tick();
      checks++;
      if (in_ready !== 1'b1 || out_res !== 32'h11) begin
         failures++;
         $display("FAIL bp_first got=%b/%h exp=1/11", in_ready, out_res);
      end
      drive(1'b1, 32'h22, 5'd2, 1'b1);
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_res !== 32'h11) begin
         failures++;
         $display("FAIL bp_full got=%b/%h exp=0/11", in_ready, out_res);
      end
      drive(1'b1, 32'h33, 5'd3, 1'b1);
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_res !== 32'h11 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_hold got=%b/%h exp=0/11", in_ready, out_res);
      end
      out_ready = 1'b1;
      tick();
      checks++;
      if (out_res !== 32'h22 || out_rd !== 5'd2 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_second got=%h/%0d/%b exp=22/2/1", out_res, out_rd, in_ready);
      end
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      checks++;
      if (out_res !== 32'h33 || out_rd !== 5'd3 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL bp_third got=%h/%0d/%b exp=33/3/1", out_res, out_rd, out_valid);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_empty got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'hA1, 5'd4, 1'b1);
      tick();
      drive(1'b1, 32'hA2, 5'd5, 1'b1);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h44, 5'd6, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_wen !== 1'b0) begin
         failures++;
         $display("FAIL flush_full got=%b%b%b exp=010", out_valid, in_ready, out_wen);
      end
      // Flush from one entry with an accept that would otherwise land.
      out_ready = 1'b1;
      drive(1'b1, 32'hB1, 5'd8, 1'b1);
      tick();
      flush = 1'b1;
      drive(1'b1, 32'h44, 5'd6, 1'b1);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_one got=%b%b exp=01", out_valid, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_discard got=%b/%h exp=0", out_valid, out_res);
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'h55, 5'd9, 1'b1);
      tick();
      drive(1'b1, 32'h66, 5'd10, 1'b1);
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_full got=%b%b exp=10", out_valid, in_ready);
      end
      rst = 1'b1;
      flush = 1'b1;
      out_ready = 1'b1;
      tick();
      rst = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      checks++;
      if ({out_valid, out_wen, out_zero, out_neg, in_ready} !== 5'b00001 ||
          out_res !== 32'h0 || out_rd !== 5'd0) begin
         failures++;
         $display("FAIL rstmid_values got=%b/%h/%0d exp=00001/00000000/0",
                  {out_valid, out_wen, out_zero, out_neg, in_ready}, out_res, out_rd);
      end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h100 + 32'(i), 5'(i), 1'b1);
         tick();
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_res !== 32'h100 + 32'(i)) begin
            failures++;
            $display("FAIL b2b_%0d got=%b%b/%h exp=11/%h", i, in_ready, out_valid, out_res,
                     32'h100 + 32'(i));
         end
      end
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_end got=%b exp=0", out_valid);
      end
   endtask

   task automatic test_random();
      logic [37:0] q[$];
      logic [37:0] exp_e;
      logic [39:0] exp_v;
      logic [39:0] got_v;
      logic        iv;
      logic        ordy;
      logic        m_ready;
      logic        m_valid;
      logic [31:0] r;
      for (int i = 0; i < 1006; i++) begin
         iv   = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
         ordy = (i < 1000) ? 1'($urandom_range(0, 1)) : 1'b1;
         r    = $urandom;
         if ($urandom_range(0, 7) == 0) r = 32'h0;
         drive(iv, r, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
         out_ready = ordy;
         m_valid = (q.size() != 0);
         m_ready = (q.size() < 2);
         checks++;
         if (out_valid !== m_valid || in_ready !== m_ready) begin
            failures++;
            $display("FAIL rand_occ_%0d got=%b%b exp=%b%b", i, out_valid, in_ready, m_valid,
                     m_ready);
         end
         if (m_valid && ordy) begin
            exp_e = q.pop_front();
            exp_v = {exp_e, (exp_e[31:0] == 32'h0), exp_e[31]};
            got_v = {out_wen, out_rd, out_res, out_zero, out_neg};
            checks++;
            if (got_v !== exp_v) begin
               failures++;
               $display("FAIL rand_data_%0d got=%h exp=%h", i, got_v, exp_v);
            end
         end
         if (iv && m_ready) q.push_back({in_wen, in_rd, in_res});
         tick();
      end
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      out_ready = 1'b0;
      checks++;
      if (q.size() != 0 || out_valid !== 1'b0) begin
         failures++;
         $display("FAIL rand_leftover got=%0d/%b exp=0/0", q.size(), out_valid);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 5'd0, 1'b0);
      test_reset();
      test_lui();
      test_zero();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_result_skid.md
Name: alu_result_skid

Overview:
- Registered two-entry skid buffer between the ALU result mux (arithmetic, logic, shift and LUI units) and the register-file writeback stage.
- Captures the ALU result plus destination tag under a valid/ready handshake, so writeback back-pressure never forces the ALU to hold combinational outputs.
- Computes registered zero/negative flags for branch and flag logic downstream.

Parameters:
- N, 32, data width of ALU result (LUI places A[N/2-1:0] in result upper half, so N must be even).
- RA_W, 5, register address width of destination tag.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- flush  input  1  synchronous squash of all buffered entries (branch redirect)
- in_valid  input  1  ALU result valid this cycle
- in_ready  output  1  buffer can accept an entry this cycle
- in_res  input  N  ALU result (any unit, incl. LUI)
- in_rd  input  RA_W  destination register index
- in_wen  input  1  instruction writes register file
- out_valid  output  1  head entry valid
- out_ready  input  1  writeback accepts head entry this cycle
- out_res  output  N  head entry result
- out_rd  output  RA_W  head entry destination
- out_wen  output  1  head write enable, forced 0 when out_valid=0
- out_zero  output  1  head out_res == 0
- out_neg  output  1  head out_res[N-1]

Behaviour:
- Storage: main slot M (drives outputs) and skid slot S; each holds {res, rd, wen, zero, neg, valid}.
- Reset (rst=1 at edge): M.valid=S.valid=0; out_valid=0, out_wen=0, out_res=0, out_rd=0, out_zero=0, out_neg=0; in_ready=1 in the cycle after reset.
- in_ready is a registered signal equal to !S.valid; never combinationally depends on out_ready.
- Accept = in_valid & in_ready; Drain = out_valid & out_ready.
- Latency: an entry accepted in cycle t appears on outputs in cycle t+1 (when M empty, or M drained in t).
- Flags are computed from in_res at capture and registered alongside it; never recomputed from outputs.
- State table (M.valid, S.valid):
  - EMPTY (0,0): Accept -> M<=in, go ONE.
  - ONE (1,0): Accept&Drain -> M<=in, stay ONE. Accept&!Drain -> S<=in, go FULL, in_ready<=0. Drain only -> go EMPTY. Neither -> hold.
  - FULL (1,1): Drain -> M<=S, S.valid<=0, go ONE, in_ready<=1. No Drain -> hold. in_valid is ignored (in_ready=0).
- (0,1) is illegal and unreachable; an assertion flags it in simulation.
- Ordering: strict FIFO. S is never presented ahead of M.
- flush=1: M.valid<=0, S.valid<=0, in_ready<=1 next cycle, and any same-cycle Accept is discarded. A Drain in the same cycle still completes, since writeback samples in that cycle.
- rst has priority over flush; both are synchronous.
- Data fields of invalid slots: don't-care internally. out_wen is gated to 0 whenever out_valid=0.
- No combinational path from in_* to out_*, or from out_ready to in_ready.

Decomposition:
- Shared package (alu_pkg): constant N_DEFAULT=32, RA_W_DEFAULT=5, and the entry struct/field widths {res, rd, wen, zero, neg}. The ALU op codes (incl. LUI) stay in the same package for downstream decode use.
- One natural sub-module: result_slot (a single load-enabled entry register with valid, sync reset, and flag computation on load), instantiated twice for M and S. Control logic stays in the top.

Test Plan:
- Reset then single LUI: in_res=0xABCD0000 (A=0x0000ABCD), in_rd=3, in_wen=1, out_ready=1 -> next cycle out_valid=1, out_res=0xABCD0000, out_rd=3, out_neg=1, out_zero=0; following cycle out_valid=0.
- Back-pressure: out_ready=0, push 0x11, 0x22 on consecutive cycles -> in_ready falls to 0 the cycle after the second accept; third push 0x33 is held by the source. Raise out_ready -> outputs 0x11, 0x22, 0x33 in order, no loss or duplication.
- Zero flag: in_res=0x00000000, in_wen=0 -> out_zero=1, out_neg=0, out_wen=0 while out_valid=1.
- Flush while FULL with a simultaneous in_valid (0x44) -> next cycle out_valid=0, in_ready=1, and 0x44 is never output.
- Reset mid-stream: FULL with 0x55/0x66, rst=1 for one cycle alongside flush=1 and out_ready=1 -> all outputs at reset values next cycle, in_ready=1.
- Random throughput: 1000 random in_valid/out_ready patterns vs a scoreboard queue -> exact in-order match; sustained 1 entry/cycle when out_ready is held at 1.
